// File: rtl/avr_cpu_core.sv
// Compact AVR-subset core with a 32x8 register file and SREG, single-issue and in-order.
// It fetches from a synchronous code ROM and uses a synchronous byte-wide data RAM.
module avr_cpu_core (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pc,
    input  logic [15:0] cdata,
    output logic [15:0] data_addr,
    output logic        data_wen,
    output logic        data_ren,
    input  logic [7:0]  data_read,
    output logic [7:0]  data_write
);
    localparam int FC = 0, FZ = 1, FN = 2, FV = 3, FS = 4, FH = 5;

    typedef enum logic [2:0] {K_NONE, K_ADD, K_SUB, K_AND, K_OR, K_EOR, K_MOV} alu_kind_e;

    logic [15:0] pc_q, pc_d, ipc_q, ipc_d;
    logic        valid_q, valid_d, ld_wb_q, ld_wb_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [7:0]  regs_q [32];
    logic [7:0]  regs_d [32];
    logic [7:0]  sreg_q, sreg_d;

    alu_kind_e   kind;
    logic        imm_fmt, exec, use_c, wr_en, mem_ok;
    logic [4:0]  rd_idx, rr_idx, ptr_lo;
    logic [7:0]  rd_val, rr_val, b_val, cin, add_r, sub_r, res;
    logic [15:0] ptr, ptr_inc;

    function automatic logic [7:0] arith_flags(input logic [7:0] s_old, input logic sub,
                                               input logic keep_z, input logic [7:0] a,
                                               input logic [7:0] b, input logic [7:0] r);
        logic [7:0] s;
        s = s_old;
        if (sub) begin
            s[FH] = (~a[3] & b[3]) | (b[3] & r[3]) | (r[3] & ~a[3]);
            s[FV] = (a[7] & ~b[7] & ~r[7]) | (~a[7] & b[7] & r[7]);
            s[FC] = (~a[7] & b[7]) | (b[7] & r[7]) | (r[7] & ~a[7]);
        end else begin
            s[FH] = (a[3] & b[3]) | (b[3] & ~r[3]) | (~r[3] & a[3]);
            s[FV] = (a[7] & b[7] & ~r[7]) | (~a[7] & ~b[7] & r[7]);
            s[FC] = (a[7] & b[7]) | (b[7] & ~r[7]) | (~r[7] & a[7]);
        end
        s[FN] = r[7];
        // Carry-chained compares only keep Z set if every earlier byte was zero too.
        s[FZ] = (r == 8'h00) & (~keep_z | s_old[FZ]);
        s[FS] = s[FN] ^ s[FV];
        return s;
    endfunction

    function automatic logic [7:0] nz_flags(input logic [7:0] s_old, input logic v,
                                            input logic [7:0] r);
        logic [7:0] s;
        s = s_old;
        s[FV] = v;
        s[FN] = r[7];
        s[FZ] = (r == 8'h00);
        s[FS] = r[7] ^ v;
        return s;
    endfunction

    function automatic logic [7:0] shift_flags(input logic [7:0] s_old, input logic c,
                                               input logic [7:0] r);
        logic [7:0] s;
        s = nz_flags(s_old, r[7] ^ c, r);
        s[FC] = c;
        return s;
    endfunction

    assign pc      = pc_q;
    assign exec    = valid_q && !ld_wb_q && !reset;
    assign imm_fmt = (cdata[15:12] inside {4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE});
    assign rd_idx  = imm_fmt ? {1'b1, cdata[7:4]} : cdata[8:4];
    assign rr_idx  = {cdata[9], cdata[3:0]};
    assign rd_val  = regs_q[rd_idx];
    assign rr_val  = regs_q[rr_idx];
    assign b_val   = imm_fmt ? {cdata[11:8], cdata[3:0]} : rr_val;
    assign use_c   = (cdata[15:10] == 6'b000001) || (cdata[15:10] == 6'b000010) ||
                     (cdata[15:10] == 6'b000111) || (cdata[15:12] == 4'h4);
    assign cin     = {7'd0, use_c & sreg_q[FC]};
    assign add_r   = rd_val + b_val + cin;
    assign sub_r   = rd_val - b_val - cin;

    assign ptr_lo  = (cdata[3:2] == 2'b11) ? 5'd26 : (cdata[3:2] == 2'b10) ? 5'd28 : 5'd30;
    assign ptr     = {regs_q[{ptr_lo[4:1], 1'b1}], regs_q[ptr_lo]};
    assign ptr_inc = ptr + 16'd1;
    assign mem_ok  = !cdata[1] && (cdata[3:2] != 2'b01);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        pc_d       = pc_q + 16'd1;
        ipc_d      = pc_q;
        valid_d    = 1'b1;
        ld_wb_d    = 1'b0;
        ld_rd_d    = ld_rd_q;
        regs_d     = regs_q;
        sreg_d     = sreg_q;
        data_addr  = '0;
        data_ren   = 1'b0;
        data_wen   = 1'b0;
        data_write = '0;
        kind       = K_NONE;
        wr_en      = 1'b0;
        res        = '0;

        if (ld_wb_q && !reset) begin
            regs_d[ld_rd_q] = data_read;
        end

        if (exec) begin
            casez (cdata[15:10])
                6'b000001: kind = K_SUB;
                6'b000010: begin kind = K_SUB; wr_en = 1'b1; end
                6'b000011: begin kind = K_ADD; wr_en = 1'b1; end
                6'b000101: kind = K_SUB;
                6'b000110: begin kind = K_SUB; wr_en = 1'b1; end
                6'b000111: begin kind = K_ADD; wr_en = 1'b1; end
                6'b001000: begin kind = K_AND; wr_en = 1'b1; end
                6'b001001: begin kind = K_EOR; wr_en = 1'b1; end
                6'b001010: begin kind = K_OR;  wr_en = 1'b1; end
                6'b001011: begin kind = K_MOV; wr_en = 1'b1; end
                6'b0011??: kind = K_SUB;
                6'b0100??: begin kind = K_SUB; wr_en = 1'b1; end
                6'b0101??: begin kind = K_SUB; wr_en = 1'b1; end
                6'b0110??: begin kind = K_OR;  wr_en = 1'b1; end
                6'b0111??: begin kind = K_AND; wr_en = 1'b1; end
                6'b1110??: begin kind = K_MOV; wr_en = 1'b1; end
                6'b100101: if (!cdata[9]) begin
                    wr_en = 1'b1;
                    case (cdata[3:0])
                        4'h0: begin
                            res = ~rd_val;
                            sreg_d = nz_flags(sreg_q, 1'b0, res);
                            sreg_d[FC] = 1'b1;
                        end
                        4'h1: begin
                            res = 8'h00 - rd_val;
                            sreg_d = arith_flags(sreg_q, 1'b1, 1'b0, 8'h00, rd_val, res);
                        end
                        4'h2: res = {rd_val[3:0], rd_val[7:4]};
                        4'h3: begin
                            res = rd_val + 8'd1;
                            sreg_d = nz_flags(sreg_q, res == 8'h80, res);
                        end
                        4'h5: begin
                            res = {rd_val[7], rd_val[7:1]};
                            sreg_d = shift_flags(sreg_q, rd_val[0], res);
                        end
                        4'h6: begin
                            res = {1'b0, rd_val[7:1]};
                            sreg_d = shift_flags(sreg_q, rd_val[0], res);
                        end
                        4'h7: begin
                            res = {sreg_q[FC], rd_val[7:1]};
                            sreg_d = shift_flags(sreg_q, rd_val[0], res);
                        end
                        4'hA: begin
                            res = rd_val - 8'd1;
                            sreg_d = nz_flags(sreg_q, res == 8'h7F, res);
                        end
                        default: wr_en = 1'b0;
                    endcase
                end
                6'b100100: if (mem_ok) begin
                    data_addr = ptr;
                    if (cdata[0]) begin
                        regs_d[ptr_lo] = ptr_inc[7:0];
                        regs_d[{ptr_lo[4:1], 1'b1}] = ptr_inc[15:8];
                    end
                    if (cdata[9]) begin
                        data_wen   = 1'b1;
                        data_write = regs_q[cdata[8:4]];
                    end else begin
                        // Hold the fetch so the word behind LD is refetched after writeback.
                        data_ren = 1'b1;
                        pc_d     = pc_q;
                        ipc_d    = ipc_q;
                        ld_wb_d  = 1'b1;
                        ld_rd_d  = cdata[8:4];
                    end
                end
                6'b1100??: begin
                    pc_d    = ipc_q + 16'd1 + {{4{cdata[11]}}, cdata[11:0]};
                    valid_d = 1'b0;
                end
                6'b11110?: if (sreg_q[cdata[2:0]] ^ cdata[10]) begin
                    pc_d    = ipc_q + 16'd1 + {{9{cdata[9]}}, cdata[9:3]};
                    valid_d = 1'b0;
                end
                default: ;
            endcase

            case (kind)
                K_ADD: begin
                    res = add_r;
                    sreg_d = arith_flags(sreg_q, 1'b0, 1'b0, rd_val, b_val, add_r);
                end
                K_SUB: begin
                    res = sub_r;
                    sreg_d = arith_flags(sreg_q, 1'b1, use_c, rd_val, b_val, sub_r);
                end
                K_AND: begin res = rd_val & b_val; sreg_d = nz_flags(sreg_q, 1'b0, res); end
                K_OR:  begin res = rd_val | b_val; sreg_d = nz_flags(sreg_q, 1'b0, res); end
                K_EOR: begin res = rd_val ^ b_val; sreg_d = nz_flags(sreg_q, 1'b0, res); end
                K_MOV: res = b_val;
                default: ;
            endcase

            if (wr_en) begin
                regs_d[rd_idx] = res;
            end
        end
    end

    // NOTE: state updates use nonblocking assignments; blocking is reserved for the _d logic above.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            ld_wb_q <= 1'b0;
            ld_rd_q <= '0;
            sreg_q  <= '0;
            // NOTE: the register file is built from flops, so it is cleared here like any other state.
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            ld_wb_q <= ld_wb_d;
            ld_rd_q <= ld_rd_d;
            sreg_q  <= sreg_d;
            regs_q  <= regs_d;
        end
    end
endmodule

// File: tb/tb_avr_cpu_core.sv
// Directed bench for avr_cpu_core: a code ROM and data RAM model with hand-computed
// expectations for arithmetic, flags, memory access, jumps, branches and reset.
module tb_avr_cpu_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc, cdata, data_addr;
    logic        data_wen, data_ren;
    logic [7:0]  data_read, data_write;

    logic [15:0] rom [256];
    logic [7:0]  ram [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_addr = 8'h00, tb_data = 8'h00;
    int          wen_pulses = 0;
    int          n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    avr_cpu_core dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .cdata      (cdata),
        .data_addr  (data_addr),
        .data_wen   (data_wen),
        .data_ren   (data_ren),
        .data_read  (data_read),
        .data_write (data_write)
    );

    always @(posedge clk) begin
        cdata <= rom[pc[7:0]];
        if (tb_we) ram[tb_addr] <= tb_data;
        else if (data_wen) ram[data_addr[7:0]] <= data_write;
        if (data_ren) data_read <= ram[data_addr[7:0]];
        if (data_wen) wen_pulses <= wen_pulses + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_reset();
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic end_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Arithmetic program followed by a store through X.
        start_reset();
        rom[0]  = 16'h0000; rom[1]  = 16'he011; rom[2]  = 16'he019; rom[3]  = 16'he022;
        rom[4]  = 16'he033; rom[5]  = 16'he044; rom[6]  = 16'h5042; rom[7]  = 16'h1b43;
        rom[8]  = 16'he1a0; rom[9]  = 16'he0b0; rom[10] = 16'h934c; rom[11] = 16'hcfff;
        end_reset();
        check("rst_pc", pc, 16'h0000);
        check("rst_strobes", {14'd0, data_wen, data_ren}, 16'h0000);
        check("rst_addr", data_addr, 16'h0000);
        check("rst_wdata", {8'h00, data_write}, 16'h0000);
        check("rst_r17", {8'h00, dut.regs_q[17]}, 16'h0000);
        check("rst_sreg", {8'h00, dut.sreg_q}, 16'h0000);
        cycles(1);
        check("fetch_pc1", pc, 16'h0001);
        cycles(7);
        check("subi_r20", {8'h00, dut.regs_q[20]}, 16'h0002);
        cycles(1);
        check("sub_r20", {8'h00, dut.regs_q[20]}, 16'h00FF);
        check("sub_sreg", {8'h00, dut.sreg_q}, 16'h0035);
        check("ldi_r17", {8'h00, dut.regs_q[17]}, 16'h0009);
        check("ldi_r18", {8'h00, dut.regs_q[18]}, 16'h0002);
        check("ldi_r19", {8'h00, dut.regs_q[19]}, 16'h0003);
        cycles(2);
        check("st_wen", {15'd0, data_wen}, 16'h0001);
        check("st_addr", data_addr, 16'h0010);
        check("st_wdata", {8'h00, data_write}, 16'h00FF);
        cycles(4);
        check("st_ram", {8'h00, ram[16]}, 16'h00FF);
        check("st_pulses", wen_pulses[15:0], 16'h0001);
        check("ldi_keeps_sreg", {8'h00, dut.sreg_q}, 16'h0035);

        // RJMP .-1 loops with the follower word always squashed.
        start_reset();
        rom[0] = 16'hcfff; rom[1] = 16'hef0f;
        end_reset();
        cycles(1);
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("rjmp_pc_lo", pc, 16'h0000);
            cycles(1);
            check("rjmp_pc_hi", pc, 16'h0001);
        end
        check("rjmp_no_follow", {8'h00, dut.regs_q[16]}, 16'h0000);

        // LD with post-increment, then LD whose target is part of the pointer.
        start_reset();
        poke(8'h20, 8'h5A);
        poke(8'h21, 8'h77);
        rom[0] = 16'he2a0; rom[1] = 16'he0b0; rom[2] = 16'h905d;
        rom[3] = 16'he0c3; rom[4] = 16'h91ad; rom[5] = 16'hcfff;
        end_reset();
        cycles(3);
        check("ld_ren", {15'd0, data_ren}, 16'h0001);
        check("ld_addr", data_addr, 16'h0020);
        check("ld_pc_issue", pc, 16'h0003);
        cycles(1);
        check("ld_pc_stall", pc, 16'h0003);
        check("ld_wb_ren", {15'd0, data_ren}, 16'h0000);
        check("ld_xinc", {dut.regs_q[27], dut.regs_q[26]}, 16'h0021);
        check("ld_r5_early", {8'h00, dut.regs_q[5]}, 16'h0000);
        cycles(1);
        check("ld_r5", {8'h00, dut.regs_q[5]}, 16'h005A);
        check("ld_pc_resume", pc, 16'h0004);
        cycles(1);
        check("ld_follower", {8'h00, dut.regs_q[28]}, 16'h0003);
        check("ld2_addr", data_addr, 16'h0021);
        cycles(2);
        check("ld_ptr_wins", {dut.regs_q[27], dut.regs_q[26]}, 16'h0077);

        // INC wrap and overflow, BREQ skipping one word.
        start_reset();
        rom[0] = 16'hef0f; rom[1] = 16'h9503; rom[2] = 16'hf009; rom[3] = 16'he011;
        rom[4] = 16'he70f; rom[5] = 16'h9503; rom[6] = 16'hcfff;
        end_reset();
        cycles(3);
        check("inc_wrap_r16", {8'h00, dut.regs_q[16]}, 16'h0000);
        check("inc_wrap_sreg", {8'h00, dut.sreg_q}, 16'h0002);
        cycles(1);
        check("breq_pc", pc, 16'h0004);
        cycles(3);
        check("inc_ovf_r16", {8'h00, dut.regs_q[16]}, 16'h0080);
        check("inc_ovf_sreg", {8'h00, dut.sreg_q}, 16'h000C);
        check("breq_skipped", {8'h00, dut.regs_q[17]}, 16'h0000);

        // Reset asserted during LD writeback abandons the load.
        start_reset();
        rom[0] = 16'he2a0; rom[1] = 16'he0b0; rom[2] = 16'h905d; rom[3] = 16'hcfff;
        end_reset();
        cycles(4);
        reset = 1'b1;
        cycles(1);
        check("rstld_r5", {8'h00, dut.regs_q[5]}, 16'h0000);
        check("rstld_pc", pc, 16'h0000);
        check("rstld_strobes", {14'd0, data_wen, data_ren}, 16'h0000);
        reset = 1'b0;
        cycles(1);
        check("rstld_r5_after", {8'h00, dut.regs_q[5]}, 16'h0000);
        check("rstld_pc_after", pc, 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
